framebuffer_fill_controller: RTL
================================

# framebuffer_fill_controller

Rectangle-fill sequencer for the 160x120, 1-bit dual-port framebuffer. It accepts one fill command at a time over a valid/ready handshake and raster-walks the inclusive rectangle. It drives the framebuffer write port (write_addr, data, we) at one pixel per clock in the write_clock domain. It is used for screen clears and for drawing solid boxes, and is the single owner of the framebuffer write port.

## Interface

**Parameters**
- DATA_WIDTH, 1: pixel width; matches the framebuffer.
- ADDR_WIDTH, 15: framebuffer address width.
- H_RES, 160: pixels per row.
- V_RES, 120: rows.

**Ports**
- write_clock, input, 1: the single clock. All logic is rising-edge.
- reset_n, input, 1: asynchronous, active-low reset.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: controller can accept a command.
- cmd_x0, input, 8: left column, inclusive.
- cmd_y0, input, 7: top row, inclusive.
- cmd_x1, input, 8: right column, inclusive.
- cmd_y1, input, 7: bottom row, inclusive.
- cmd_color, input, DATA_WIDTH: fill value.
- abort, input, 1: terminate the current fill.
- write_addr, output, ADDR_WIDTH: framebuffer write address.
- data, output, DATA_WIDTH: framebuffer write data.
- we, output, 1: framebuffer write enable.
- busy, output, 1: fill in progress.
- done, output, 1: one-cycle pulse after the last pixel of a completed fill.
- cmd_error, output, 1: one-cycle pulse when a command is rejected.

## Operation

- All outputs are registered.
- Reset values: cmd_ready=0, write_addr=0, data=0, we=0, busy=0, done=0, cmd_error=0. State is IDLE.
- cmd_ready goes to 1 on the first edge after reset_n deasserts.

**States**
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid && cmd_ready, the command fields are checked.
  - The command is valid when x0<=x1<H_RES and y0<=y1<V_RES.
  - Valid command: latch x0, x1, y1, color. Load write_addr = y0*H_RES + x0, data=color, we=1, busy=1, cmd_ready=0. Go to FILL.
  - Invalid command: cmd_error=1 for one cycle. No write occurs. Stay in IDLE with cmd_ready=1.
- FILL: one pixel is presented per cycle with we=1, and cur_x/cur_y track the presented pixel.
  - cur_x<x1: cur_x+1 and write_addr+1.
  - cur_x==x1 and cur_y<y1: cur_x=x0, cur_y+1, and write_addr += H_RES-(x1-x0).
  - cur_x==x1 and cur_y==y1: we=0, busy=0, done=1, cmd_ready=1. Go to IDLE.
  - abort=1 in FILL takes priority over advancing. Next edge: we=0, busy=0, cmd_ready=1, done=0. Go to IDLE. The pixel presented during the abort cycle is still written.
- abort in IDLE is ignored.
- cmd_valid in FILL is ignored, because cmd_ready=0.

**Arithmetic**
- y0*H_RES is implemented as (y0<<7)+(y0<<5) for H_RES=160. A generic constant multiply is used otherwise.
- write_addr never exceeds H_RES*V_RES-1 = 19199. There is no wrap-around, because commands are bounds-checked.

**Reset mid-fill**
- Asynchronous return to reset values. we drops immediately.
- A partially written rectangle stays in memory.

## Timing

- Accept at edge N: the first write (x0,y0) is presented during cycle N+1, with we high from edge N to N+1.
- A W x H rectangle produces exactly W*H consecutive we cycles with no gaps, including at row wraps.
- done asserts W*H cycles after edge N, on the same edge we falls. cmd_ready is high in that same cycle.
- A back-to-back command can be accepted on the edge ending the done cycle. The new first write follows 1 cycle later, so there is 1 idle cycle between fills.
- cmd_error is asserted in the cycle after the rejecting edge.

## Test plan

- **Full clear:** (0,0)-(159,119), color 1.
  - 19200 consecutive we cycles, addresses 0..19199 in order, data=1.
  - done fires exactly once, 19200 cycles after accept.
- **Box:** (40,30)-(119,89), color 0.
  - 4800 writes, first address 4840.
  - Row 30 ends at 4919; the next address is 5000.
  - Last address 14359, data=0 throughout.
- **Single pixel:** (159,119).
  - One write at 19199, then done.
  - Back-to-back (0,0)-(0,0) is accepted at done and writes address 0 one cycle later.
- **Invalid commands:** x1=160; and x0=10 with x1=9.
  - One-cycle cmd_error each, no we, cmd_ready stays 1.
- **Abort:** raise abort on the 100th write cycle of a full clear.
  - Exactly 100 writes (addresses 0..99), then we=0, busy=0, no done, cmd_ready=1.
- **Reset mid-fill:** pull reset_n low mid-fill.
  - we, busy, and cmd_ready go to 0 asynchronously.
  - After release, cmd_ready=1 one edge later and a new command executes normally.

Source files
------------

// File: rtl/framebuffer_fill_controller.sv
// Rectangle-fill sequencer for a 1-bit framebuffer.
// Raster-walks an inclusive box, one pixel write per clock.
module framebuffer_fill_controller #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 15,
  parameter int H_RES      = 160,
  parameter int V_RES      = 120
) (
  input  logic                  write_clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [7:0]            cmd_x0,
  input  logic [6:0]            cmd_y0,
  input  logic [7:0]            cmd_x1,
  input  logic [6:0]            cmd_y1,
  input  logic [DATA_WIDTH-1:0] cmd_color,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  we,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_error
);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            x0_q, x0_d;
  logic [7:0]            x1_q, x1_d;
  logic [6:0]            y1_q, y1_d;
  logic [7:0]            cur_x_q, cur_x_d;
  logic [6:0]            cur_y_q, cur_y_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cmd_error_q, cmd_error_d;

  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] wrap_addr;
  logic                  cmd_ok;
  logic                  col_more;
  logic                  row_more;

  // Row base uses shift-add for the native 160-pixel line.
  generate
    if (H_RES == 160) begin : g_shift
      assign row_base = (ADDR_WIDTH'(cmd_y0) << 7)
                      + (ADDR_WIDTH'(cmd_y0) << 5);
    end else begin : g_mul
      assign row_base = ADDR_WIDTH'(cmd_y0)
                      * ADDR_WIDTH'(H_RES);
    end
  endgenerate

  assign start_addr = row_base + ADDR_WIDTH'(cmd_x0);
  assign wrap_addr  = write_addr_q + ADDR_WIDTH'(H_RES)
                    - ADDR_WIDTH'(x1_q) + ADDR_WIDTH'(x0_q);

  assign cmd_ok = (cmd_x0 <= cmd_x1)
               && (32'(cmd_x1) < H_RES)
               && (cmd_y0 <= cmd_y1)
               && (32'(cmd_y1) < V_RES);

  assign col_more = cur_x_q != x1_q;
  assign row_more = cur_y_q != y1_q;

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    write_addr_d = write_addr_q;
    data_d       = data_q;
    cmd_ready_d  = cmd_ready_q;
    we_d         = we_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cmd_error_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        we_d        = 1'b0;
        busy_d      = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_ok) begin
            x0_d         = cmd_x0;
            x1_d         = cmd_x1;
            y1_d         = cmd_y1;
            cur_x_d      = cmd_x0;
            cur_y_d      = cmd_y0;
            write_addr_d = start_addr;
            data_d       = cmd_color;
            we_d         = 1'b1;
            busy_d       = 1'b1;
            cmd_ready_d  = 1'b0;
            state_d      = FILL;
          end else begin
            cmd_error_d  = 1'b1;
          end
        end
      end
      FILL: begin
        unique case (1'b1)
          abort: begin
            we_d        = 1'b0;
            busy_d      = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
          end
          (!abort && col_more): begin
            cur_x_d      = cur_x_q + 8'd1;
            write_addr_d = write_addr_q + 1'b1;
          end
          (!abort && !col_more && row_more): begin
            cur_x_d      = x0_q;
            cur_y_d      = cur_y_q + 7'd1;
            write_addr_d = wrap_addr;
          end
          (!abort && !col_more && !row_more): begin
            we_d        = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge write_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      x0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      write_addr_q <= '0;
      data_q       <= '0;
      cmd_ready_q  <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cmd_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      write_addr_q <= write_addr_d;
      data_q       <= data_d;
      cmd_ready_q  <= cmd_ready_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cmd_error_q  <= cmd_error_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign write_addr = write_addr_q;
  assign data       = data_q;
  assign we         = we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cmd_error  = cmd_error_q;

endmodule
